// File: rtl/clk_lock_monitor.sv
// rtl/clk_lock_monitor.sv - divided-clock frequency lock monitor with downstream reset hold
//
// Counts rising edges of tick_in over fixed windows of refclk cycles and
// declares lock after LOCK_WINDOWS consecutive in-tolerance windows. Once
// locked, rst_out is held for RST_HOLD further cycles before release. Any
// out-of-tolerance window while locked drops lock and pulses lock_lost.
//
// Ports:
//   refclk     in   reference clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   tick_in    in   monitored divided clock, sampled as data
//   locked     out  high while settling or locked
//   rst_out    out  downstream reset, low only when fully locked
//   lock_lost  out  one-cycle pulse when lock is dropped
//   edge_count out  edge total of the last completed window
module clk_lock_monitor #(
    parameter int WINDOW       = 16,
    parameter int EXPECT       = 8,
    parameter int TOL          = 1,
    parameter int LOCK_WINDOWS = 4,
    parameter int RST_HOLD     = 8
) (
    input  logic                       refclk,
    input  logic                       rst,
    input  logic                       tick_in,
    output logic                       locked,
    output logic                       rst_out,
    output logic                       lock_lost,
    output logic [$clog2(WINDOW):0]    edge_count
);

    localparam int CW  = $clog2(WINDOW) + 1;
    localparam int WCW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int GCW = (LOCK_WINDOWS > 1) ? $clog2(LOCK_WINDOWS) : 1;
    localparam int HCW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    // Lower bound clamps at zero so a wide tolerance cannot wrap around.
    localparam int LO = (EXPECT > TOL) ? (EXPECT - TOL) : 0;
    localparam int HI = EXPECT + TOL;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic             prev;
    logic [WCW-1:0]   win_cnt;
    logic [CW-1:0]    edge_cnt;
    logic [GCW-1:0]   good_cnt;
    logic [HCW-1:0]   hold_cnt;

    logic             rise;
    logic             win_end;
    logic [CW-1:0]    total;
    logic [31:0]      total_ext;
    logic             good;

    always_comb begin
        rise      = tick_in & ~prev;
        win_end   = (win_cnt == WCW'(WINDOW - 1));
        // Saturating edge_cnt + rise; this also serves as the next edge_cnt.
        total     = (rise && (edge_cnt != {CW{1'b1}})) ? edge_cnt + 1'b1 : edge_cnt;
        total_ext = 32'(total);
        good      = (total_ext >= 32'(LO)) && (total_ext <= 32'(HI));
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state      <= SEARCH;
            prev       <= 1'b0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            good_cnt   <= '0;
            hold_cnt   <= '0;
            edge_count <= '0;
            locked     <= 1'b0;
            rst_out    <= 1'b1;
            lock_lost  <= 1'b0;
        end else begin
            prev      <= tick_in;
            lock_lost <= 1'b0;

            if (win_end) begin
                win_cnt    <= '0;
                edge_cnt   <= '0;
                edge_count <= total;
            end else begin
                win_cnt  <= win_cnt + 1'b1;
                edge_cnt <= total;
            end

            case (state)
                SEARCH: begin
                    if (win_end) begin
                        if (!good) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GCW'(LOCK_WINDOWS - 1)) begin
                            state    <= SETTLE;
                            good_cnt <= '0;
                            hold_cnt <= '0;
                            locked   <= 1'b1;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                end

                SETTLE: begin
                    // A bad window wins over hold expiry in the same cycle.
                    if (win_end && !good) begin
                        state     <= SEARCH;
                        good_cnt  <= '0;
                        hold_cnt  <= '0;
                        locked    <= 1'b0;
                        rst_out   <= 1'b1;
                        lock_lost <= 1'b1;
                    end else if (hold_cnt == HCW'(RST_HOLD - 1)) begin
                        state   <= LOCKED;
                        rst_out <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                LOCKED: begin
                    if (win_end && !good) begin
                        state     <= SEARCH;
                        good_cnt  <= '0;
                        hold_cnt  <= '0;
                        locked    <= 1'b0;
                        rst_out   <= 1'b1;
                        lock_lost <= 1'b1;
                    end
                end

                default: begin
                    state   <= SEARCH;
                    locked  <= 1'b0;
                    rst_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_lock_monitor.sv
// tb/tb_clk_lock_monitor.sv - self-checking bench for clk_lock_monitor
module tb_clk_lock_monitor;

    logic refclk = 1'b0;
    logic rst;
    logic tick_in;

    always #5 refclk = ~refclk;

    // a: defaults; b: long settle hold; c: 32-cycle window so 9/10 edges fit
    logic       a_locked, a_rst_out, a_lost;
    logic [4:0] a_ec;
    logic       b_locked, b_rst_out, b_lost;
    logic [4:0] b_ec;
    logic       c_locked, c_rst_out, c_lost;
    logic [5:0] c_ec;

    clk_lock_monitor dut_a (
        .refclk(refclk), .rst(rst), .tick_in(tick_in),
        .locked(a_locked), .rst_out(a_rst_out), .lock_lost(a_lost), .edge_count(a_ec)
    );

    clk_lock_monitor #(.WINDOW(16), .EXPECT(8), .TOL(1), .LOCK_WINDOWS(4), .RST_HOLD(20)) dut_b (
        .refclk(refclk), .rst(rst), .tick_in(tick_in),
        .locked(b_locked), .rst_out(b_rst_out), .lock_lost(b_lost), .edge_count(b_ec)
    );

    clk_lock_monitor #(.WINDOW(32), .EXPECT(8), .TOL(1), .LOCK_WINDOWS(4), .RST_HOLD(8)) dut_c (
        .refclk(refclk), .rst(rst), .tick_in(tick_in),
        .locked(c_locked), .rst_out(c_rst_out), .lock_lost(c_lost), .edge_count(c_ec)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: window totals are recounted from the raw sample history;
    // lock is tracked as "in lock since cycle S", with reset released at S+hold.
    int cfg_w  [3] = '{16, 16, 32};
    int cfg_e  [3] = '{8, 8, 8};
    int cfg_t  [3] = '{1, 1, 1};
    int cfg_lw [3] = '{4, 4, 4};
    int cfg_h  [3] = '{8, 20, 8};
    int cfg_wd [3] = '{5, 5, 6};

    logic hist[$];
    int   m_cyc;
    int   m_streak [3];
    bit   m_in_lock[3];
    int   m_start  [3];
    int   m_ec     [3];
    bit   m_lost   [3];
    bit   x_rst_out[3];

    task automatic model_step(input logic t, input logic r);
        if (r) begin
            hist.delete();
            m_cyc = 0;
            for (int i = 0; i < 3; i++) begin
                m_streak[i] = 0; m_in_lock[i] = 0; m_start[i] = 0;
                m_ec[i] = 0; m_lost[i] = 0; x_rst_out[i] = 1;
            end
            return;
        end
        hist.push_back(t);
        if (hist.size() > 40) void'(hist.pop_front());
        for (int i = 0; i < 3; i++) begin
            m_lost[i] = 0;
            if (m_cyc % cfg_w[i] == cfg_w[i] - 1) begin
                int  total;
                bit  good;
                total = 0;
                for (int j = 0; j < cfg_w[i]; j++) begin
                    int   idx;
                    logic pv;
                    idx = hist.size() - cfg_w[i] + j;
                    pv  = (idx > 0) ? hist[idx-1] : 1'b0;
                    if (hist[idx] && !pv) total++;
                end
                if (total > (1 << cfg_wd[i]) - 1) total = (1 << cfg_wd[i]) - 1;
                m_ec[i] = total;
                good = (total >= cfg_e[i] - cfg_t[i]) && (total <= cfg_e[i] + cfg_t[i]);
                if (!m_in_lock[i]) begin
                    if (good) m_streak[i]++;
                    else      m_streak[i] = 0;
                    if (m_streak[i] == cfg_lw[i]) begin
                        m_in_lock[i] = 1;
                        m_start[i]   = m_cyc + 1;
                        m_streak[i]  = 0;
                    end
                end else if (!good) begin
                    m_in_lock[i] = 0;
                    m_lost[i]    = 1;
                    m_streak[i]  = 0;
                end
            end
        end
        m_cyc++;
        for (int i = 0; i < 3; i++)
            x_rst_out[i] = !(m_in_lock[i] && (m_cyc >= m_start[i] + cfg_h[i]));
    endtask

    // Drive one cycle at the falling edge, update the model at the rising
    // edge, and compare every output at the next falling edge.
    task automatic do_cycle(input logic t, input logic r);
        tick_in = t;
        rst     = r;
        @(posedge refclk);
        model_step(t, r);
        @(negedge refclk);
        chk("a.locked",     a_locked,  m_in_lock[0]);
        chk("a.rst_out",    a_rst_out, x_rst_out[0]);
        chk("a.lock_lost",  a_lost,    m_lost[0]);
        chk("a.edge_count", a_ec,      m_ec[0]);
        chk("b.locked",     b_locked,  m_in_lock[1]);
        chk("b.rst_out",    b_rst_out, x_rst_out[1]);
        chk("b.lock_lost",  b_lost,    m_lost[1]);
        chk("b.edge_count", b_ec,      m_ec[1]);
        chk("c.locked",     c_locked,  m_in_lock[2]);
        chk("c.rst_out",    c_rst_out, x_rst_out[2]);
        chk("c.lock_lost",  c_lost,    m_lost[2]);
        chk("c.edge_count", c_ec,      m_ec[2]);
    endtask

    task automatic do_reset();
        do_cycle(1'b0, 1'b1);
        chk("reset.locked",     a_locked,  0);
        chk("reset.rst_out",    a_rst_out, 1);
        chk("reset.lock_lost",  a_lost,    0);
        chk("reset.edge_count", a_ec,      0);
    endtask

    typedef struct {
        int         edges;
        logic [5:0] exp_ec;
        logic       exp_locked;
        logic       exp_rst_out;
        logic       exp_lost;
    } win_vec_t;

    win_vec_t vecs[11];

    initial begin
        int lost_seen;
        int ka;
        rst     = 1'b1;
        tick_in = 1'b0;

        // Tolerance windows on dut_c (32 cycles each), checked at the cycle after each window end
        vecs[0]  = '{8,  6'd8,  1'b0, 1'b1, 1'b0};
        vecs[1]  = '{9,  6'd9,  1'b0, 1'b1, 1'b0};
        vecs[2]  = '{10, 6'd10, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{7,  6'd7,  1'b0, 1'b1, 1'b0};
        vecs[4]  = '{6,  6'd6,  1'b0, 1'b1, 1'b0};
        vecs[5]  = '{8,  6'd8,  1'b0, 1'b1, 1'b0};
        vecs[6]  = '{7,  6'd7,  1'b0, 1'b1, 1'b0};
        vecs[7]  = '{9,  6'd9,  1'b0, 1'b1, 1'b0};
        vecs[8]  = '{8,  6'd8,  1'b1, 1'b1, 1'b0};
        vecs[9]  = '{8,  6'd8,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{10, 6'd10, 1'b0, 1'b1, 1'b1};

        do_reset();
        foreach (vecs[v]) begin
            for (int k = 0; k < 32; k++)
                do_cycle((k % 2 == 1) && (k < 2 * vecs[v].edges), 1'b0);
            chk($sformatf("tbl%0d.edge_count", v), c_ec,      vecs[v].exp_ec);
            chk($sformatf("tbl%0d.locked", v),     c_locked,  vecs[v].exp_locked);
            chk($sformatf("tbl%0d.rst_out", v),    c_rst_out, vecs[v].exp_rst_out);
            chk($sformatf("tbl%0d.lock_lost", v),  c_lost,    vecs[v].exp_lost);
        end

        // Lock acquisition then loss: toggle from 0, stop at cycle 100
        do_reset();
        lost_seen = 0;
        for (int k = 0; k < 120; k++) begin
            do_cycle((k < 100) ? 1'(k % 2) : 1'b0, 1'b0);
            if (k + 1 <= 100 && a_lost) lost_seen++;
            case (k + 1)
                15:  chk("acq.ec15",      a_ec,      0);
                16:  chk("acq.ec16",      a_ec,      8);
                63:  chk("acq.locked63",  a_locked,  0);
                64:  chk("acq.locked64",  a_locked,  1);
                71:  chk("acq.rstout71",  a_rst_out, 1);
                72:  chk("acq.rstout72",  a_rst_out, 0);
                111: chk("loss.lost111",  a_lost,    0);
                112: begin
                    chk("loss.lost112",    a_lost,    1);
                    chk("loss.locked112",  a_locked,  0);
                    chk("loss.rstout112",  a_rst_out, 1);
                    chk("loss.ec112",      a_ec,      2);
                end
                113: chk("loss.lost113",  a_lost,    0);
                default: ;
            endcase
        end
        chk("acq.no_lock_lost", lost_seen, 0);

        // Bad window during SETTLE on dut_b (hold 20): window 64..79 silent
        do_reset();
        ka = 0;
        for (int k = 0; k < 100; k++) begin
            do_cycle((k >= 64 && k < 80) ? 1'b0 : 1'(k % 2), 1'b0);
            if (!b_rst_out) ka++;
            if (k + 1 == 79) chk("settle.locked79", b_locked, 1);
            if (k + 1 == 80) begin
                chk("settle.lost80",   b_lost,   1);
                chk("settle.locked80", b_locked, 0);
            end
            if (k + 1 == 81) chk("settle.lost81", b_lost, 0);
        end
        chk("settle.rst_out_never_low", ka, 0);

        // No clock: stuck low then stuck high
        do_reset();
        for (int k = 0; k < 80; k++) begin
            do_cycle(1'b0, 1'b0);
            if (k + 1 == 16 || k + 1 == 48) chk("stuck0.ec", a_ec, 0);
        end
        chk("stuck0.locked",  a_locked,  0);
        chk("stuck0.rst_out", a_rst_out, 1);
        do_reset();
        for (int k = 0; k < 80; k++) begin
            do_cycle(1'b1, 1'b0);
            if (k + 1 == 16) chk("stuck1.ec16", a_ec, 1);
            if (k + 1 == 32) chk("stuck1.ec32", a_ec, 0);
        end
        chk("stuck1.locked",  a_locked,  0);
        chk("stuck1.rst_out", a_rst_out, 1);

        // One-cycle reset at cycle 40, then reacquire
        do_reset();
        for (int k = 0; k < 40; k++) do_cycle(1'(k % 2), 1'b0);
        chk("midrst.ec_before", a_ec, 8);
        do_cycle(1'b0, 1'b1);
        chk("midrst.ec",      a_ec,      0);
        chk("midrst.lost",    a_lost,    0);
        chk("midrst.rst_out", a_rst_out, 1);
        for (int k = 0; k < 80; k++) begin
            do_cycle(1'(k % 2), 1'b0);
            if (k + 1 == 63) chk("midrst.locked63", a_locked, 0);
            if (k + 1 == 64) chk("midrst.locked64", a_locked, 1);
            if (k + 1 == 72) chk("midrst.rstout72", a_rst_out, 0);
        end

        // Randomised windows against the model
        do_reset();
        for (int w = 0; w < 120; w++) begin
            int mode;
            mode = $urandom_range(0, 4);
            for (int k = 0; k < 16; k++) begin
                logic t;
                case (mode)
                    0, 1:    t = 1'(k % 2);
                    2:       t = 1'(k % 2) ^ ($urandom_range(0, 15) == 0);
                    3:       t = 1'($urandom_range(0, 1));
                    default: t = 1'(w % 2);
                endcase
                do_cycle(t, $urandom_range(0, 399) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_lock_monitor.md
CLK_LOCK_MONITOR -- requirements
Module: clk_lock_monitor

Interface
REQ-001 Parameter WINDOW, default 16: length of one measurement window, in refclk cycles.
REQ-002 Parameter EXPECT, default 8: expected tick_in rising edges per window (25MHz divided clock against a 50MHz refclk).
REQ-003 Parameter TOL, default 1: allowed absolute deviation from EXPECT.
REQ-004 Parameter LOCK_WINDOWS, default 4: consecutive good windows required to declare lock.
REQ-005 Parameter RST_HOLD, default 8: refclk cycles that rst_out stays asserted after lock.
REQ-006 refclk  input  1  sole clock; all logic SHALL run on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 tick_in  input  1  monitored divided clock, sampled as data on refclk.
REQ-009 locked  output  1  high while states SETTLE or LOCKED.
REQ-010 rst_out  output  1  downstream reset; high unless state is LOCKED.
REQ-011 lock_lost  output  1  one-cycle pulse on each transition from SETTLE/LOCKED to SEARCH.
REQ-012 edge_count  output  $clog2(WINDOW)+1  edge total of the last completed window.

Function
REQ-013 Edge detection SHALL use a registered copy prev of tick_in: rise = tick_in & ~prev. prev resets to 0, so tick_in high in the first cycle after reset counts as one edge.
REQ-014 win_cnt SHALL count 0..WINDOW-1 and wrap to 0; the cycle with win_cnt==WINDOW-1 is the window end.
REQ-015 edge_cnt SHALL increment on rise and saturate at all-ones.
- At window end: total = edge_cnt + rise (saturating).
- edge_cnt clears to 0 on the following edge.
- edge_count latches total on the same edge.
REQ-016 A window is good iff EXPECT-TOL <= total <= EXPECT+TOL. Comparison is unsigned and SHALL NOT underflow when TOL >= EXPECT.
REQ-017 State machine SHALL have three states: SEARCH, SETTLE, LOCKED. Reset state is SEARCH.
REQ-018 SEARCH transitions, evaluated at window end only:
- Good window: good_cnt increments.
- Bad window: good_cnt clears to 0.
- Good window with good_cnt==LOCK_WINDOWS-1: go to SETTLE and clear good_cnt.
REQ-019 SETTLE: hold_cnt counts RST_HOLD cycles starting from 0 on entry; at hold_cnt==RST_HOLD-1 go to LOCKED.
REQ-020 A bad window end in SETTLE or LOCKED SHALL go to SEARCH, clear good_cnt and hold_cnt, and pulse lock_lost for the next cycle.
- In SETTLE, a bad window end takes priority over hold expiry in the same cycle.
REQ-021 Good windows in SETTLE or LOCKED SHALL cause no state change.
REQ-022 All outputs SHALL be registered: a decision at the window-end edge is visible on outputs in the next cycle.

Reset
REQ-023 While rst is high at a refclk edge, the following SHALL all be cleared on that edge:
- win_cnt, edge_cnt, good_cnt, hold_cnt, prev and edge_count = 0.
- state = SEARCH.
- locked = 0, lock_lost = 0, rst_out = 1.
REQ-024 Reset asserted mid-window or mid-SETTLE SHALL discard partial counts, SHALL NOT pulse lock_lost, and SHALL restart the first window at cycle 0 after deassertion.

Verification
REQ-025 Lock acquisition (cycle 0 = first cycle after rst deasserts): tick_in toggles every cycle starting at 0 -> edge_count=8 from cycle 16; locked=1 from cycle 64; rst_out=0 from cycle 72; lock_lost never pulses.
REQ-026 No clock: tick_in stuck at 0 or stuck at 1 -> edge_count=0 (stuck at 1 gives 1 in window one only); locked stays 0 and rst_out stays 1 indefinitely.
REQ-027 Tolerance boundary: windows with 7 and 9 edges -> counted good; a window with 6 or 10 edges -> good_cnt resets to 0; the lock time is extended accordingly.
REQ-028 Loss of lock: after locking per REQ-025, stop toggling at cycle 100 -> the window ending at cycle 111 is bad; lock_lost=1 in cycle 112 only; locked=0 and rst_out=1 from cycle 112.
REQ-029 Bad window in SETTLE: lock per REQ-025 with WINDOW=16 and RST_HOLD=20, and make the window ending at cycle 79 bad -> SEARCH, lock_lost pulse in cycle 80, rst_out never drops.
REQ-030 Reset mid-operation: assert rst for 1 cycle at cycle 40 -> all outputs return to reset values the next cycle, with no lock_lost pulse; lock is reacquired 64 cycles after deassertion.
